// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        RUN,
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        CHK,
        ERR
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int CSUM_W     = 8;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles big-endian bytes into 32-bit words; word_done pulses with the 4th byte.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [8*(WORD_BYTES-1)-1:0] shift;
    logic [1:0]                  cnt;

    // The word is presented combinationally so the top can register it on the same edge.
    assign word      = {shift, byte_data};
    assign word_done = byte_valid && (cnt == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (byte_valid) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (byte_valid) begin
            shift <= {shift[8*(WORD_BYTES-2)-1:0], byte_data};
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader / write-port owner for instruction memory.
// Optional checksum byte after the image is enabled with `define IMEM_LOADER_CHECKSUM_EN.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W         = 9,
    parameter int MAX_WORDS      = 512,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] cpu_fetch_addr,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int HDR_W = 8 * HDR_BYTES;
    localparam int TW    = $clog2(TIMEOUT_CYCLES);

    state_t            state, next_state;
    logic              accept;
    logic              start;
    logic              busy_state;
    logic              timeout;
    logic              data_byte;
    logic              hdr_ok;
    logic              last_word;
    logic [7:0]        hdr_hi;
    logic [HDR_W-1:0]  hdr_n;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W-1:0] word_idx;
    logic [TW-1:0]     tmo_cnt;
    logic [31:0]       pk_word;
    logic              pk_done;

    assign accept     = rx_valid && rx_ready;
    assign data_byte  = accept && (state == DATA);
    assign busy_state = state inside {HDR_HI, HDR_LO, DATA, WRITE, CHK};
    assign timeout    = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign hdr_n      = {hdr_hi, rx_data};
    assign hdr_ok     = (hdr_n != '0) && (hdr_n <= HDR_W'(MAX_WORDS));
    assign last_word  = ((ADDR_W+1)'(word_idx) + (ADDR_W+1)'(1)) == n_words;

    // The CPU owns the memory port only while the loader is idle.
    assign imem_addr  = (state == RUN) ? cpu_fetch_addr : word_idx;

    imem_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start),
        .byte_valid (data_byte),
        .byte_data  (rx_data),
        .word       (pk_word),
        .word_done  (pk_done)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0] csum;

    always_ff @(posedge clk) begin
        if (start) begin
            csum <= '0;
        end else if (data_byte) begin
            csum <= csum + rx_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        case (state)
            RUN, ERR: begin
                if (load_req) begin
                    start      = 1'b1;
                    next_state = HDR_HI;
                end
            end
            HDR_HI: if (accept) next_state = HDR_LO;
            HDR_LO: if (accept) next_state = hdr_ok ? DATA : ERR;
            DATA:   if (pk_done) next_state = WRITE;
            WRITE: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    next_state = CHK;
`else
                    next_state = RUN;
`endif
                end else begin
                    next_state = DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:    if (accept) next_state = (rx_data == csum) ? RUN : ERR;
`endif
            default: next_state = RUN;
        endcase
        if (busy_state && timeout && !accept) begin
            next_state = ERR;
        end
    end

    // Registered outputs are derived from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_reset    <= 1'b0;
            busy         <= 1'b0;
            imem_we      <= 1'b0;
            rx_ready     <= 1'b1;
            error        <= 1'b0;
            imem_wdata   <= '0;
            tmo_cnt      <= '0;
            word_idx     <= '0;
            words_loaded <= '0;
        end else begin
            cpu_reset <= (next_state != RUN);
            busy      <= next_state inside {HDR_HI, HDR_LO, DATA, WRITE, CHK};
            imem_we   <= (next_state == WRITE);
            rx_ready  <= (next_state != WRITE);
            error     <= (next_state == ERR);

            if ((next_state != state) || accept) begin
                tmo_cnt <= '0;
            end else if (busy_state) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (start) begin
                word_idx     <= '0;
                words_loaded <= '0;
            end else if (state == WRITE) begin
                word_idx     <= word_idx + 1'b1;
                words_loaded <= words_loaded + 1'b1;
            end

            if (pk_done) begin
                imem_wdata <= pk_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && (state == HDR_HI)) begin
            hdr_hi <= rx_data;
        end
        if (accept && (state == HDR_LO) && hdr_ok) begin
            n_words <= hdr_n[ADDR_W:0];
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed plus randomized bench for imem_boot_loader against an image-level reference model.
module tb_imem_boot_loader;

    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_req;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic [ADDR_W-1:0] cpu_fetch_addr;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_we;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int passed = 0;
    int total  = 0;

    logic [31:0] img [0:511];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];

    imem_boot_loader #(
        .ADDR_W         (ADDR_W),
        .MAX_WORDS      (512),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_req       (load_req),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .cpu_fetch_addr (cpu_fetch_addr),
        .imem_addr      (imem_addr),
        .imem_we        (imem_we),
        .imem_wdata     (imem_wdata),
        .cpu_reset      (cpu_reset),
        .busy           (busy),
        .error          (error),
        .words_loaded   (words_loaded)
    );

    always #5 clk = ~clk;

    // Write log seen by the memory.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(32'(imem_addr));
            wr_data.push_back(imem_wdata);
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("rx_ready_wait", 32'(rx_ready), 32'd1);
        else @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Sends header, N words and (when enabled) a checksum, then checks the write log.
    task automatic run_load(input int n, input bit gaps, input bit bad_csum);
        logic [31:0] w;
        logic [15:0] nh;
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] sum;
        sum = 8'h00;
`endif
        nh = 16'(n);
        wr_addr.delete();
        wr_data.delete();
        cpu_fetch_addr = 9'($urandom);
        pulse_load();
        check("load_busy", 32'(busy), 32'd1);
        check("load_cpu_reset", 32'(cpu_reset), 32'd1);
        send_byte(nh[15:8]);
        send_byte(nh[7:0]);
        for (int i = 0; i < n; i++) begin
            w = img[i];
            for (int b = 3; b >= 0; b--) begin
                if (gaps) idle($urandom_range(0, 2));
                send_byte(w[8*b +: 8]);
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum = sum + w[8*b +: 8];
`endif
            end
        end
        check("last_we", 32'(imem_we), 32'd1);
        check("last_rx_ready", 32'(rx_ready), 32'd0);
        check("last_cpu_reset", 32'(cpu_reset), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? (sum ^ 8'h01) : sum);
        check("csum_cpu_reset", 32'(cpu_reset), bad_csum ? 32'd1 : 32'd0);
        check("csum_error", 32'(error), bad_csum ? 32'd1 : 32'd0);
`else
        @(negedge clk);
        check("done_cpu_reset", 32'(cpu_reset), 32'd0);
        check("done_error", 32'(error), 32'd0);
        check("done_addr_mux", 32'(imem_addr), 32'(cpu_fetch_addr));
`endif
        check("done_busy", 32'(busy), 32'd0);
        check("done_words_loaded", 32'(words_loaded), 32'(n));
        check("write_count", 32'(wr_addr.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check("write_addr", wr_addr[i], 32'(i));
            check("write_data", wr_data[i], img[i]);
        end
    endtask

    initial begin
        reset          = 1'b1;
        load_req       = 1'b0;
        rx_valid       = 1'b0;
        rx_data        = 8'h00;
        cpu_fetch_addr = 9'h123;
        idle(3);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_addr_mux", 32'(imem_addr), 32'h123);
        reset = 1'b0;
        idle(2);

        // Reference image; load_req together with a byte in RUN, plus a load_req mid-load.
        wr_addr.delete();
        wr_data.delete();
        load_req = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        @(negedge clk);
        load_req = 1'b0;
        rx_valid = 1'b0;
        check("dir_busy", 32'(busy), 32'd1);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h08); send_byte(8'h10);
        pulse_load();
        send_byte(8'h00); send_byte(8'h03);
        check("dir_we0", 32'(imem_we), 32'd1);
        check("dir_addr0", 32'(imem_addr), 32'd0);
        send_byte(8'h20); send_byte(8'h15); send_byte(8'h00); send_byte(8'h01);
        check("dir_we1", 32'(imem_we), 32'd1);
        check("dir_cpu_reset_hold", 32'(cpu_reset), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h08 + 8'h10 + 8'h03 + 8'h20 + 8'h15 + 8'h01);
`else
        @(negedge clk);
`endif
        check("dir_cpu_reset_fall", 32'(cpu_reset), 32'd0);
        check("dir_words", 32'(words_loaded), 32'd2);
        check("dir_nwrites", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("dir_wa0", wr_addr[0], 32'd0);
            check("dir_wd0", wr_data[0], 32'h08100003);
            check("dir_wa1", wr_addr[1], 32'd1);
            check("dir_wd1", wr_data[1], 32'h20150001);
        end

        // Header N=0 rejected.
        wr_addr.delete();
        pulse_load();
        send_byte(8'h00); send_byte(8'h00);
        check("n0_error", 32'(error), 32'd1);
        check("n0_cpu_reset", 32'(cpu_reset), 32'd1);
        check("n0_busy", 32'(busy), 32'd0);
        send_byte(8'h33);
        check("err_discard_error", 32'(error), 32'd1);
        check("err_rx_ready", 32'(rx_ready), 32'd1);
        pulse_load();
        check("err_clear", 32'(error), 32'd0);

        // Header N=513 rejected (load already started above).
        send_byte(8'h02); send_byte(8'h01);
        check("n513_error", 32'(error), 32'd1);
        check("n513_cpu_reset", 32'(cpu_reset), 32'd1);
        check("hdr_err_no_we", 32'(wr_addr.size()), 32'd0);

        // Timeout after 5 bytes.
        pulse_load();
        check("tmo_clear", 32'(error), 32'd0);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        idle(95);
        check("tmo_before", 32'(error), 32'd0);
        check("tmo_busy_before", 32'(busy), 32'd1);
        idle(10);
        check("tmo_after", 32'(error), 32'd1);
        check("tmo_cpu_reset", 32'(cpu_reset), 32'd1);
        check("tmo_busy_after", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) img[i] = $urandom;
        run_load(3, 1'b0, 1'b0);

        // N=MAX_WORDS accepted, then reset during DATA.
        pulse_load();
        send_byte(8'h02); send_byte(8'h00);
        check("nmax_error", 32'(error), 32'd0);
        check("nmax_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        wr_addr.delete();
        cpu_fetch_addr = 9'h0A5;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_cpu_reset", 32'(cpu_reset), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_addr", 32'(imem_addr), 32'h0A5);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        idle(3);
        check("rst_mid_no_writes", 32'(wr_addr.size()), 32'd0);
        check("rst_mid_cpu_free", 32'(cpu_reset), 32'd0);

        // Randomized images with irregular byte spacing.
        for (int t = 0; t < 4; t++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) img[i] = $urandom;
            run_load(n, 1'b1, 1'b0);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        img[0] = 32'h01020304;
        run_load(1, 1'b0, 1'b0);
        run_load(1, 1'b0, 1'b1);
        check("csum_bad_latched", 32'(error), 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
